alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode-and-issue pipeline stage directly upstream of the execute ALU. Accepts one RV32I instruction per cycle with its PC and register-file read data, decodes it to the ALU's 5-bit function code, selects and width-conditions both operands, and registers them toward execute behind a valid/ready handshake. Also produces the branch-condition sense that execute applies to the ALU's `result_equal_zero`.

## Interface
- `XLEN`, 32: operand/data width; only 32 supported.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous discard of all held entries.
- `in_valid` input 1: upstream instruction valid.
- `in_ready` output 1: stage can accept this cycle.
- `in_instr` input 32: RV32I instruction word.
- `in_pc` input 32: instruction PC.
- `in_rs1_data`, `in_rs2_data` input 32 each: register read data.
- `out_valid` output 1: issue entry valid.
- `out_ready` input 1: execute accepts this cycle.
- `out_alu_function` output 5: ADD=1 SUB=2 SLL=3 SRL=4 SRA=5 SEQ=6 SLT=7 SLTU=8 XOR=9 OR=10 AND=11; 0 = none/illegal.
- `out_operand_a`, `out_operand_b` output 32 each: ALU operands.
- `out_rd` output 5: destination register (0 for branch/store).
- `out_is_branch` output 1: conditional branch.
- `out_branch_on_zero` output 1: branch taken when `result_equal_zero`=1.
- `out_illegal` output 1: unsupported opcode/funct.

## Operation
- OP (0x33): funct3/funct7[5] select function; a=rs1, b=rs2; SLL/SRL/SRA b masked to rs2[4:0].
- OP-IMM (0x13): a=rs1, b=sign-extended I-imm; SLLI/SRLI/SRAI b=instr[24:20]; funct7[5]=1 selects SRAI; SUB not encodable.
- LUI (0x37): ADD, a=0, b=U-imm. AUIPC (0x17): ADD, a=pc, b=U-imm.
- LOAD (0x03)/STORE (0x23): ADD, a=rs1, b=I/S-imm; STORE rd=0.
- BRANCH (0x63): a=rs1, b=rs2, rd=0, is_branch=1. BEQ: SUB, on_zero=1. BNE: SUB, 0. BLT: SLT, 0. BGE: SLT, 1. BLTU: SLTU, 0. BGEU: SLTU, 1. funct3 2/3 illegal.
- Any other opcode/funct: function 0, illegal=1, operands 0, entry still passes through in order.
- Buffer FSM: EMPTY → ONE on accept; ONE → FULL on accept with out_ready=0; ONE → EMPTY on out_ready, no accept; FULL → ONE on out_ready (skid entry moves to main, no new accept); ONE with accept and out_ready stays ONE.
- `in_ready` = (state != FULL), registered, no combinational path from `out_ready`.
- `flush` highest priority: state → EMPTY next edge; input that cycle discarded.

## Timing
- Latency 1 cycle: accepted at edge N → `out_valid` visible after edge N.
- Throughput 1/cycle with `out_ready` held high.
- Outputs stable while `out_valid`=1 and `out_ready`=0.
- Reset: state EMPTY, `out_valid`=0, `in_ready`=1, all data outputs 0.
- Reset mid-operation drops both entries, no partial output.

## Configuration
- `ALU_ISSUE_SKID_EN` defined: two-entry skid buffer as above, registered `in_ready`.
- Undefined: single register, states EMPTY/ONE only; `in_ready` = !out_valid || out_ready (combinational); full throughput kept, timing path through `in_ready`.

## Structure
- Package `alu_pkg`: `alu_op_e` enum with codes above, RV32I opcode constants, `issue_state_e` (EMPTY, ONE, FULL), `issue_entry_t` struct (function, operands, rd, branch flags, illegal).
- Sub-module `alu_decoder`: purely combinational instr/pc/rs data → `issue_entry_t`; top holds FSM and registers.

## Test plan
- ADD 0x002081B3, rs1=5, rs2=7 → next cycle function=1, a=5, b=7, rd=3, illegal=0.
- SRAI 0x40335293, rs1=0x80000000 → function=5, a=0x80000000, b=3, rd=5.
- BGE 0x0020D463 → function=7, is_branch=1, on_zero=1, rd=0.
- out_ready=0, send three ADDs back-to-back → in_ready=0 after second; third held upstream; out_ready=1 → emitted in order 1,2,3, no loss or duplicate.
- State FULL, assert flush → out_valid=0, in_ready=1 next cycle.
- Instr 0x0000007F → function=0, illegal=1, a=b=0, out_valid=1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared types for the ALU issue stage: ALU function codes,
//             RV32I opcodes, issue-buffer states and the issue entry record.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int unsigned c_XLEN = 32;

  // ALU function codes as consumed by the execute stage
  typedef enum logic [4:0] {
    ALU_NONE = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_SLL  = 5'd3,
    ALU_SRL  = 5'd4,
    ALU_SRA  = 5'd5,
    ALU_SEQ  = 5'd6,
    ALU_SLT  = 5'd7,
    ALU_SLTU = 5'd8,
    ALU_XOR  = 5'd9,
    ALU_OR   = 5'd10,
    ALU_AND  = 5'd11
  } alu_op_e;

  // RV32I major opcodes handled by the decoder
  localparam logic [6:0] c_OPC_OP     = 7'h33;
  localparam logic [6:0] c_OPC_OP_IMM = 7'h13;
  localparam logic [6:0] c_OPC_LUI    = 7'h37;
  localparam logic [6:0] c_OPC_AUIPC  = 7'h17;
  localparam logic [6:0] c_OPC_LOAD   = 7'h03;
  localparam logic [6:0] c_OPC_STORE  = 7'h23;
  localparam logic [6:0] c_OPC_BRANCH = 7'h63;

  // Occupancy of the issue buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } issue_state_e;

  typedef struct packed {
    alu_op_e           alu_function;
    logic [c_XLEN-1:0] operand_a;
    logic [c_XLEN-1:0] operand_b;
    logic [4:0]        rd;
    logic              is_branch;
    logic              branch_on_zero;
    logic              illegal;
  } issue_entry_t;

  localparam issue_entry_t c_ENTRY_ZERO = '{
    alu_function: ALU_NONE, operand_a: '0, operand_b: '0, rd: 5'd0,
    is_branch: 1'b0, branch_on_zero: 1'b0, illegal: 1'b0};

  localparam issue_entry_t c_ENTRY_ILLEGAL = '{
    alu_function: ALU_NONE, operand_a: '0, operand_b: '0, rd: 5'd0,
    is_branch: 1'b0, branch_on_zero: 1'b0, illegal: 1'b1};

  // Sign-extend a 12-bit immediate to the data width
  function automatic logic [c_XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(c_XLEN-12){imm[11]}}, imm};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Combinational RV32I decode of one instruction into an issue
//             entry (ALU function, conditioned operands, rd, branch sense).
//             Unsupported encodings yield an all-zero entry flagged illegal.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
  import alu_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  input  logic [31:0]  rs1_data,
  input  logic [31:0]  rs2_data,
  output issue_entry_t entry
);

  logic [6:0]   w_opcode;
  logic [2:0]   w_funct3;
  logic [6:0]   w_funct7;
  logic [4:0]   w_rd;
  logic [31:0]  w_imm_i;
  logic [31:0]  w_imm_s;
  logic [31:0]  w_imm_u;
  logic [31:0]  w_shamt;
  issue_entry_t w_dec;
  logic         w_legal;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_rd     = instr[11:7];
  assign w_imm_i  = sext12(instr[31:20]);
  assign w_imm_s  = sext12({instr[31:25], instr[11:7]});
  assign w_imm_u  = {instr[31:12], 12'h000};
  assign w_shamt  = {27'd0, instr[24:20]};

  // Opcode/funct decode; any unrecognised field combination clears w_legal
  always_comb begin
    w_dec   = c_ENTRY_ZERO;
    w_legal = 1'b1;
    case (w_opcode)
      c_OPC_OP: begin
        w_dec.operand_a = rs1_data;
        w_dec.operand_b = rs2_data;
        w_dec.rd        = w_rd;
        if (w_funct7 == 7'h00) begin
          case (w_funct3)
            3'd0:    w_dec.alu_function = ALU_ADD;
            3'd1:    w_dec.alu_function = ALU_SLL;
            3'd2:    w_dec.alu_function = ALU_SLT;
            3'd3:    w_dec.alu_function = ALU_SLTU;
            3'd4:    w_dec.alu_function = ALU_XOR;
            3'd5:    w_dec.alu_function = ALU_SRL;
            3'd6:    w_dec.alu_function = ALU_OR;
            default: w_dec.alu_function = ALU_AND;
          endcase
        end else if (w_funct7 == 7'h20 && w_funct3 == 3'd0) begin
          w_dec.alu_function = ALU_SUB;
        end else if (w_funct7 == 7'h20 && w_funct3 == 3'd5) begin
          w_dec.alu_function = ALU_SRA;
        end else begin
          w_legal = 1'b0;
        end
        // Register shifts only honour the low five bits of rs2
        if (w_funct3 == 3'd1 || w_funct3 == 3'd5) begin
          w_dec.operand_b = {27'd0, rs2_data[4:0]};
        end
      end
      c_OPC_OP_IMM: begin
        w_dec.operand_a = rs1_data;
        w_dec.operand_b = w_imm_i;
        w_dec.rd        = w_rd;
        case (w_funct3)
          3'd0: w_dec.alu_function = ALU_ADD;
          3'd2: w_dec.alu_function = ALU_SLT;
          3'd3: w_dec.alu_function = ALU_SLTU;
          3'd4: w_dec.alu_function = ALU_XOR;
          3'd6: w_dec.alu_function = ALU_OR;
          3'd7: w_dec.alu_function = ALU_AND;
          3'd1: begin
            w_dec.operand_b    = w_shamt;
            w_dec.alu_function = ALU_SLL;
            w_legal            = (w_funct7 == 7'h00);
          end
          default: begin
            w_dec.operand_b = w_shamt;
            if (w_funct7 == 7'h00) begin
              w_dec.alu_function = ALU_SRL;
            end else if (w_funct7 == 7'h20) begin
              w_dec.alu_function = ALU_SRA;
            end else begin
              w_legal = 1'b0;
            end
          end
        endcase
      end
      c_OPC_LUI: begin
        w_dec.alu_function = ALU_ADD;
        w_dec.operand_b    = w_imm_u;
        w_dec.rd           = w_rd;
      end
      c_OPC_AUIPC: begin
        w_dec.alu_function = ALU_ADD;
        w_dec.operand_a    = pc;
        w_dec.operand_b    = w_imm_u;
        w_dec.rd           = w_rd;
      end
      c_OPC_LOAD: begin
        w_dec.alu_function = ALU_ADD;
        w_dec.operand_a    = rs1_data;
        w_dec.operand_b    = w_imm_i;
        w_dec.rd           = w_rd;
        // LB/LH/LW/LBU/LHU only
        w_legal = (w_funct3 != 3'd3) && (w_funct3 != 3'd6) && (w_funct3 != 3'd7);
      end
      c_OPC_STORE: begin
        w_dec.alu_function = ALU_ADD;
        w_dec.operand_a    = rs1_data;
        w_dec.operand_b    = w_imm_s;
        // SB/SH/SW only
        w_legal = (w_funct3 <= 3'd2);
      end
      c_OPC_BRANCH: begin
        w_dec.operand_a = rs1_data;
        w_dec.operand_b = rs2_data;
        w_dec.is_branch = 1'b1;
        // on_zero inverts the sense for BEQ/BGE/BGEU relative to the ALU result
        case (w_funct3)
          3'd0: begin w_dec.alu_function = ALU_SUB;  w_dec.branch_on_zero = 1'b1; end
          3'd1: begin w_dec.alu_function = ALU_SUB;  w_dec.branch_on_zero = 1'b0; end
          3'd4: begin w_dec.alu_function = ALU_SLT;  w_dec.branch_on_zero = 1'b0; end
          3'd5: begin w_dec.alu_function = ALU_SLT;  w_dec.branch_on_zero = 1'b1; end
          3'd6: begin w_dec.alu_function = ALU_SLTU; w_dec.branch_on_zero = 1'b0; end
          3'd7: begin w_dec.alu_function = ALU_SLTU; w_dec.branch_on_zero = 1'b1; end
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign entry = w_legal ? w_dec : c_ENTRY_ILLEGAL;

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : Decode-and-issue stage feeding the execute ALU. Decodes one
//             RV32I instruction per cycle and registers the issue entry
//             behind a valid/ready handshake with one cycle of latency.
//  Config   : ALU_ISSUE_SKID_EN - when defined, a two-entry skid buffer with
//             a registered in_ready; otherwise a single entry register with
//             in_ready = !out_valid || out_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_alu_function,
  output logic [XLEN-1:0] out_operand_a,
  output logic [XLEN-1:0] out_operand_b,
  output logic [4:0]      out_rd,
  output logic            out_is_branch,
  output logic            out_branch_on_zero,
  output logic            out_illegal
);

  issue_entry_t w_dec;
  issue_state_e r_state;
  issue_state_e w_state_nxt;
  issue_entry_t r_main;
  logic         w_accept;
  logic         w_load_main;

  alu_decoder u_decoder (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .entry    (w_dec)
  );

  assign out_valid = (r_state != EMPTY);

`ifdef ALU_ISSUE_SKID_EN
  issue_entry_t r_skid;
  logic         r_in_ready;
  logic         w_load_skid;
  logic         w_skid_to_main;

  // Ready comes from a flop so out_ready never reaches in_ready combinationally
  assign in_ready = r_in_ready;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  assign w_accept = in_valid && in_ready;

  // Next-state and buffer load controls; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
`ifdef ALU_ISSUE_SKID_EN
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
`endif
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_load_main = 1'b1;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_accept && out_ready) begin
            w_load_main = 1'b1;
          end
`ifdef ALU_ISSUE_SKID_EN
          else if (w_accept) begin
            w_load_skid = 1'b1;
            w_state_nxt = FULL;
          end
`endif
          else if (out_ready) begin
            w_state_nxt = EMPTY;
          end
        end
`ifdef ALU_ISSUE_SKID_EN
        FULL: begin
          if (out_ready) begin
            w_skid_to_main = 1'b1;
            w_state_nxt    = ONE;
          end
        end
`endif
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Buffer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Main (output-facing) entry register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= c_ENTRY_ZERO;
    end else if (w_load_main) begin
      r_main <= w_dec;
    end
`ifdef ALU_ISSUE_SKID_EN
    else if (w_skid_to_main) begin
      r_main <= r_skid;
    end
`endif
  end

`ifdef ALU_ISSUE_SKID_EN
  // Skid entry captured when the main entry is stalled, plus registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid     <= c_ENTRY_ZERO;
      r_in_ready <= 1'b1;
    end else begin
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
      r_in_ready <= (w_state_nxt != FULL);
    end
  end
`endif

  assign out_alu_function   = r_main.alu_function;
  assign out_operand_a      = r_main.operand_a;
  assign out_operand_b      = r_main.operand_b;
  assign out_rd             = r_main.rd;
  assign out_is_branch      = r_main.is_branch;
  assign out_branch_on_zero = r_main.branch_on_zero;
  assign out_illegal        = r_main.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Self-checking bench for alu_issue_stage: directed cases plus
//             random traffic against an in-order queue reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_SKID_EN
  localparam int CAP_SKID = 1;
`else
  localparam int CAP_SKID = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [4:0]  out_alu_function;
  logic [31:0] out_operand_a;
  logic [31:0] out_operand_b;
  logic [4:0]  out_rd;
  logic        out_is_branch;
  logic        out_branch_on_zero;
  logic        out_illegal;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_instr           (in_instr),
    .in_pc              (in_pc),
    .in_rs1_data        (in_rs1_data),
    .in_rs2_data        (in_rs2_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_alu_function   (out_alu_function),
    .out_operand_a      (out_operand_a),
    .out_operand_b      (out_operand_b),
    .out_rd             (out_rd),
    .out_is_branch      (out_is_branch),
    .out_branch_on_zero (out_branch_on_zero),
    .out_illegal        (out_illegal)
  );

  typedef struct {
    logic [4:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        br;
    logic        boz;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the ISA tables
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    logic [6:0]  opc  = ins[6:0];
    logic [2:0]  f3   = ins[14:12];
    logic [6:0]  f7   = ins[31:25];
    logic [31:0] iimm = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    logic [31:0] uimm = {ins[31:12], 12'h000};
    logic [4:0]  rtab [8] = '{5'd1, 5'd3, 5'd7, 5'd8, 5'd9, 5'd4, 5'd10, 5'd11};
    logic [4:0]  btab [8] = '{5'd2, 5'd2, 5'd0, 5'd0, 5'd7, 5'd7, 5'd8, 5'd8};
    bit          ok = 1'b1;
    e = '{fn: 5'd0, a: 32'd0, b: 32'd0, rd: 5'd0, br: 1'b0, boz: 1'b0, ill: 1'b0};
    case (opc)
      7'h33: begin
        e.a  = r1;
        e.b  = (f3 == 3'd1 || f3 == 3'd5) ? (r2 & 32'h1F) : r2;
        e.rd = ins[11:7];
        if (f7 == 7'h00) e.fn = rtab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.fn = 5'd2;
        else if (f7 == 7'h20 && f3 == 3'd5) e.fn = 5'd5;
        else ok = 1'b0;
      end
      7'h13: begin
        e.a  = r1;
        e.b  = iimm;
        e.rd = ins[11:7];
        e.fn = rtab[f3];
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = {27'd0, ins[24:20]};
          if (f7 == 7'h20 && f3 == 3'd5) e.fn = 5'd5;
          else if (f7 != 7'h00) ok = 1'b0;
        end
      end
      7'h37: begin e.fn = 5'd1; e.b = uimm; e.rd = ins[11:7]; end
      7'h17: begin e.fn = 5'd1; e.a = pc; e.b = uimm; e.rd = ins[11:7]; end
      7'h03: begin
        e.fn = 5'd1; e.a = r1; e.b = iimm; e.rd = ins[11:7];
        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      end
      7'h23: begin
        e.fn = 5'd1; e.a = r1; e.b = simm;
        ok = (f3 <= 3'd2);
      end
      7'h63: begin
        e.a   = r1;
        e.b   = r2;
        e.br  = 1'b1;
        e.fn  = btab[f3];
        e.boz = (f3 == 3'd0) || (f3 == 3'd5) || (f3 == 3'd7);
        ok    = (e.fn != 5'd0);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) e = '{fn: 5'd0, a: 32'd0, b: 32'd0, rd: 5'd0, br: 1'b0, boz: 1'b0, ill: 1'b1};
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  opcs [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h0B};
    w[6:0] = opcs[$urandom_range(0, 9)];
    if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic chk_entry(input string tag, input exp_t e);
    chk({tag, ".fn"},  32'(out_alu_function),   32'(e.fn));
    chk({tag, ".a"},   out_operand_a,           e.a);
    chk({tag, ".b"},   out_operand_b,           e.b);
    chk({tag, ".rd"},  32'(out_rd),             32'(e.rd));
    chk({tag, ".br"},  32'(out_is_branch),      32'(e.br));
    chk({tag, ".boz"}, 32'(out_branch_on_zero), 32'(e.boz));
    chk({tag, ".ill"}, 32'(out_illegal),        32'(e.ill));
  endtask

  // One clock: drive at negedge, check against the model, advance the model at posedge
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic fl,
                       output bit acc, output bit fire, output exp_t popped);
    bit exp_rdy;
    @(negedge clk);
    in_valid    = v;
    in_instr    = ins;
    in_pc       = pc;
    in_rs1_data = r1;
    in_rs2_data = r2;
    out_ready   = ordy;
    flush       = fl;
    #1;
    exp_rdy = (CAP_SKID != 0) ? (q.size() < 2) : (q.size() == 0 || ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk_entry("head", q[0]);
    acc  = v && exp_rdy && !fl;
    fire = (q.size() > 0) && ordy && !fl;
    popped = '{fn: 5'd0, a: 32'd0, b: 32'd0, rd: 5'd0, br: 1'b0, boz: 1'b0, ill: 1'b0};
    if (q.size() > 0) popped = q[0];
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) q.push_back(ref_decode(ins, pc, r1, r2));
    end
  endtask

  initial begin
    bit          acc;
    bit          fire;
    exp_t        pop;
    int          p;
    logic [31:0] seen[$];

    // Reset state
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.fn",        32'(out_alu_function), 32'd0);
    chk("rst.a",         out_operand_a, 32'd0);
    chk("rst.b",         out_operand_b, 32'd0);
    chk("rst.rd",        32'(out_rd), 32'd0);
    chk("rst.ill",       32'(out_illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x3, x1, x2
    cycle(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0, acc, fire, pop);
    #1;
    chk("add.valid", 32'(out_valid), 32'd1);
    chk("add.fn", 32'(out_alu_function), 32'd1);
    chk("add.a", out_operand_a, 32'd5);
    chk("add.b", out_operand_b, 32'd7);
    chk("add.rd", 32'(out_rd), 32'd3);
    chk("add.ill", 32'(out_illegal), 32'd0);

    // SRAI x5, x6, 3
    cycle(1'b1, 32'h40335293, 32'h104, 32'h80000000, 32'h12345678, 1'b1, 1'b0, acc, fire, pop);
    #1;
    chk("srai.fn", 32'(out_alu_function), 32'd5);
    chk("srai.a", out_operand_a, 32'h80000000);
    chk("srai.b", out_operand_b, 32'd3);
    chk("srai.rd", 32'(out_rd), 32'd5);

    // BGE x1, x2
    cycle(1'b1, 32'h0020D463, 32'h108, 32'd9, 32'd4, 1'b1, 1'b0, acc, fire, pop);
    #1;
    chk("bge.fn", 32'(out_alu_function), 32'd7);
    chk("bge.br", 32'(out_is_branch), 32'd1);
    chk("bge.boz", 32'(out_branch_on_zero), 32'd1);
    chk("bge.rd", 32'(out_rd), 32'd0);

    // Unsupported opcode still passes through, zeroed and flagged
    cycle(1'b1, 32'h0000007F, 32'h10C, 32'hAAAA5555, 32'h5555AAAA, 1'b1, 1'b0, acc, fire, pop);
    #1;
    chk("ill.valid", 32'(out_valid), 32'd1);
    chk("ill.fn", 32'(out_alu_function), 32'd0);
    chk("ill.flag", 32'(out_illegal), 32'd1);
    chk("ill.a", out_operand_a, 32'd0);
    chk("ill.b", out_operand_b, 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc, fire, pop);

    // Back-pressure: three ADDs with out_ready low, then drain in order
    p = 0;
    for (int c = 0; c < 14; c++) begin
      cycle(p < 3, 32'h002081B3, 32'h200, 32'(p + 1), 32'd0, c >= 4, 1'b0, acc, fire, pop);
      if (acc) p++;
      if (fire) seen.push_back(pop.a);
      if (c == 1) begin
        #1;
        chk("bp.in_ready_after_two", 32'(in_ready), 32'd0);
      end
    end
    chk("bp.accepted", 32'(p), 32'd3);
    chk("bp.count", 32'(seen.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("bp.order", (seen.size() > i) ? seen[i] : 32'hDEAD_BEEF, 32'(i + 1));

    // Fill the buffer, then flush with a valid input in the same cycle
    cycle(1'b1, 32'h002081B3, 32'h300, 32'd11, 32'd1, 1'b0, 1'b0, acc, fire, pop);
    cycle(1'b1, 32'h002081B3, 32'h304, 32'd12, 32'd1, 1'b0, 1'b0, acc, fire, pop);
    cycle(1'b1, 32'h002081B3, 32'h308, 32'd13, 32'd1, 1'b0, 1'b1, acc, fire, pop);
    #1;
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);

    // Random traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, acc, fire, pop);
    end

    // Asynchronous reset mid-operation drops everything held
    cycle(1'b1, 32'h002081B3, 32'h400, 32'd21, 32'd1, 1'b0, 1'b0, acc, fire, pop);
    cycle(1'b1, 32'h002081B3, 32'h404, 32'd22, 32'd1, 1'b0, 1'b0, acc, fire, pop);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    q.delete();
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.in_ready", 32'(in_ready), 32'd1);
    chk("arst.fn", 32'(out_alu_function), 32'd0);
    chk("arst.a", out_operand_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'h00A00093, 32'h500, 32'd0, 32'd0, 1'b1, 1'b0, acc, fire, pop);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc, fire, pop);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
